bip_program_memory: RTL and testbench

// - Program-memory responder on the BIP instruction-fetch interface: answers PC fetch

---
 rtl/bip_program_memory_if.sv | 28 ++
 rtl/bip_program_memory.sv | 113 +++++++++++
 tb/tb_bip_program_memory.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_program_memory_if.sv
// BIP instruction-fetch and program-loader bus between the control unit/host and program memory.
interface bip_program_memory_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] Instruction;
    logic              instr_valid;
    logic              busy;
    logic              load_mode;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] load_count;
    logic              addr_err;

    modport master (
        output fetch_req, PC, load_mode, load_valid, load_addr, load_data,
        input  Instruction, instr_valid, busy, load_ready, load_count, addr_err
    );

    modport slave (
        input  fetch_req, PC, load_mode, load_valid, load_addr, load_data,
        output Instruction, instr_valid, busy, load_ready, load_count, addr_err
    );
endinterface

// File: rtl/bip_program_memory.sv
// BIP program memory: answers PC fetches with wait states and accepts host loads while stalled.
module bip_program_memory #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    bip_program_memory_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_re, mem_we;
    logic              rd_in_range, wr_in_range;

    logic [DATA_W-1:0] instr_q;
    logic              valid_q, busy_q, ready_q, err_q;
    logic [ADDR_W-1:0] count_q;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_in_range = 32'(rd_addr) < DEPTH;
    assign wr_in_range = 32'(bus.load_addr) < DEPTH;

    // Next-state and memory-port control
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pc_next       = pc_q;
        rd_addr       = pc_q;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load_mode) begin
                    state_next = LOAD;
                end else if (bus.fetch_req) begin
                    pc_next = bus.PC;
                    rd_addr = bus.PC;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        mem_re     = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (bus.load_mode) begin
                    state_next = LOAD;
                end else begin
                    wait_cnt_next = wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state_next = RESP;
                        mem_re     = 1'b1;
                    end
                end
            end
            RESP: state_next = IDLE;
            LOAD: begin
                mem_we = bus.load_valid;
                if (!bus.load_mode) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs; status flags decode the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            pc_q     <= pc_next;
            valid_q  <= (state_next == RESP);
            busy_q   <= (state_next != IDLE);
            ready_q  <= (state_next == LOAD);
            if (mem_re) instr_q <= rd_in_range ? mem[IDX_W'(rd_addr)] : '0;
            if (mem_we) count_q <= count_q + ADDR_W'(1);
            if ((mem_re && !rd_in_range) || (mem_we && !wr_in_range)) err_q <= 1'b1;
        end
    end

    // Array has no reset so loaded programs survive a core reset
    always_ff @(posedge clock) begin
        if (mem_we && wr_in_range) mem[IDX_W'(bus.load_addr)] <= bus.load_data;
    end

    assign bus.Instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.load_ready  = ready_q;
    assign bus.load_count  = count_q;
    assign bus.addr_err    = err_q;
endmodule

// File: tb/tb_bip_program_memory.sv
// Directed bench for bip_program_memory across three wait-state / depth configurations.
module tb_bip_program_memory;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clock = ~clock;

    bip_program_memory_if #(.ADDR_W(11), .DATA_W(16)) ifa ();
    bip_program_memory_if #(.ADDR_W(11), .DATA_W(16)) ifb ();
    bip_program_memory_if #(.ADDR_W(11), .DATA_W(16)) ifc ();

    bip_program_memory #(.ADDR_W(11), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    bip_program_memory #(.ADDR_W(11), .DATA_W(16), .DEPTH(2048), .WAIT_CYCLES(3))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));
    bip_program_memory #(.ADDR_W(11), .DATA_W(16), .DEPTH(2048), .WAIT_CYCLES(2))
        dut_c (.clock(clock), .reset(reset), .bus(ifc));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        total++; if (ifa.Instruction !== 16'h0000) $display("FAIL reset_instr: got %h exp 0000", ifa.Instruction); else passed++;
        total++; if (ifa.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", ifa.instr_valid); else passed++;
        total++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", ifa.busy); else passed++;
        total++; if (ifa.load_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", ifa.load_ready); else passed++;
        total++; if (ifa.load_count !== 11'd0) $display("FAIL reset_count: got %0d exp 0", ifa.load_count); else passed++;
        total++; if (ifb.addr_err !== 1'b0) $display("FAIL reset_err: got %b exp 0", ifb.addr_err); else passed++;
    endtask

    // Preload mem[5], dropping load_mode in the same cycle as the write, then fetch it
    task automatic test_fetch_nowait();
        ifa.load_mode = 1'b1;
        tick();
        total++; if (ifa.load_ready !== 1'b1) $display("FAIL t1_ready: got %b exp 1", ifa.load_ready); else passed++;
        ifa.load_mode = 1'b0; ifa.load_valid = 1'b1; ifa.load_addr = 11'd5; ifa.load_data = 16'h0803;
        tick();
        ifa.load_valid = 1'b0;
        total++; if (ifa.load_count !== 11'd1) $display("FAIL t1_count: got %0d exp 1", ifa.load_count); else passed++;
        total++; if (ifa.load_ready !== 1'b0) $display("FAIL t1_ready_off: got %b exp 0", ifa.load_ready); else passed++;
        ifa.fetch_req = 1'b1; ifa.PC = 11'd5;
        tick();
        ifa.fetch_req = 1'b0;
        total++; if (ifa.instr_valid !== 1'b1) $display("FAIL t1_valid: got %b exp 1", ifa.instr_valid); else passed++;
        total++; if (ifa.Instruction !== 16'h0803) $display("FAIL t1_instr: got %h exp 0803", ifa.Instruction); else passed++;
        total++; if (ifa.busy !== 1'b1) $display("FAIL t1_busy_resp: got %b exp 1", ifa.busy); else passed++;
        tick();
        total++; if (ifa.instr_valid !== 1'b0) $display("FAIL t1_valid_off: got %b exp 0", ifa.instr_valid); else passed++;
        total++; if (ifa.busy !== 1'b0) $display("FAIL t1_busy_off: got %b exp 0", ifa.busy); else passed++;
        total++; if (ifa.Instruction !== 16'h0803) $display("FAIL t1_hold: got %h exp 0803", ifa.Instruction); else passed++;
    endtask

    // fetch_req held high: RESP ignores it, so valid alternates 1,0,1,0
    task automatic test_back_to_back();
        ifa.fetch_req = 1'b1; ifa.PC = 11'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ifa.instr_valid !== ((i % 2) == 0))
                $display("FAIL b2b_valid[%0d]: got %b exp %b", i, ifa.instr_valid, (i % 2) == 0);
            else passed++;
        end
        ifa.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_load_then_fetch();
        ifa.load_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifa.load_valid = 1'b1; ifa.load_addr = 11'(i); ifa.load_data = 16'hA000 + 16'(i);
            tick();
        end
        ifa.load_valid = 1'b0;
        tick();
        total++; if (ifa.load_count !== 11'd5) $display("FAIL t3_count: got %0d exp 5", ifa.load_count); else passed++;
        total++; if (ifa.busy !== 1'b1) $display("FAIL t3_busy_load: got %b exp 1", ifa.busy); else passed++;
        ifa.load_mode = 1'b0;
        tick();
        ifa.fetch_req = 1'b1; ifa.PC = 11'd2;
        tick();
        ifa.fetch_req = 1'b0;
        total++; if (ifa.Instruction !== 16'hA002) $display("FAIL t3_instr: got %h exp a002", ifa.Instruction); else passed++;
        tick();
        // load_mode beats fetch_req in the same IDLE cycle
        ifa.load_mode = 1'b1; ifa.fetch_req = 1'b1; ifa.PC = 11'd1;
        tick();
        ifa.fetch_req = 1'b0; ifa.load_mode = 1'b0;
        total++; if (ifa.load_ready !== 1'b1) $display("FAIL prio_ready: got %b exp 1", ifa.load_ready); else passed++;
        total++; if (ifa.instr_valid !== 1'b0) $display("FAIL prio_valid: got %b exp 0", ifa.instr_valid); else passed++;
        tick();
        total++; if (ifa.Instruction !== 16'hA002) $display("FAIL prio_instr: got %h exp a002", ifa.Instruction); else passed++;
    endtask

    task automatic test_out_of_range();
        ifa.fetch_req = 1'b1; ifa.PC = 11'h400;
        tick();
        ifa.fetch_req = 1'b0;
        total++; if (ifa.instr_valid !== 1'b1) $display("FAIL t5_valid: got %b exp 1", ifa.instr_valid); else passed++;
        total++; if (ifa.Instruction !== 16'h0000) $display("FAIL t5_instr: got %h exp 0000", ifa.Instruction); else passed++;
        total++; if (ifa.addr_err !== 1'b1) $display("FAIL t5_err: got %b exp 1", ifa.addr_err); else passed++;
        tick();
        ifa.fetch_req = 1'b1; ifa.PC = 11'd3;
        tick();
        ifa.fetch_req = 1'b0;
        total++; if (ifa.Instruction !== 16'hA003) $display("FAIL t5_inrange: got %h exp a003", ifa.Instruction); else passed++;
        total++; if (ifa.addr_err !== 1'b1) $display("FAIL t5_sticky: got %b exp 1", ifa.addr_err); else passed++;
        tick();
        // out-of-range write is discarded but still counted
        ifa.load_mode = 1'b1;
        tick();
        ifa.load_valid = 1'b1; ifa.load_addr = 11'h7FF; ifa.load_data = 16'hFFFF;
        tick();
        ifa.load_valid = 1'b0; ifa.load_mode = 1'b0;
        total++; if (ifa.load_count !== 11'd6) $display("FAIL t5_wcount: got %0d exp 6", ifa.load_count); else passed++;
        tick();
    endtask

    task automatic test_wait_states();
        ifb.load_mode = 1'b1;
        tick();
        ifb.load_valid = 1'b1; ifb.load_addr = 11'd0; ifb.load_data = 16'h1001;
        tick();
        ifb.load_addr = 11'd1; ifb.load_data = 16'h2222;
        tick();
        ifb.load_valid = 1'b0; ifb.load_mode = 1'b0;
        tick();
        ifb.fetch_req = 1'b1; ifb.PC = 11'd0;
        tick();
        ifb.fetch_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ifb.instr_valid !== (i == 3))
                $display("FAIL t2_valid[%0d]: got %b exp %b", i, ifb.instr_valid, i == 3);
            else passed++;
            total++;
            if (ifb.busy !== (i < 4))
                $display("FAIL t2_busy[%0d]: got %b exp %b", i, ifb.busy, i < 4);
            else passed++;
            if (i == 3) begin
                total++; if (ifb.Instruction !== 16'h1001) $display("FAIL t2_instr: got %h exp 1001", ifb.Instruction); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_wait_abort();
        ifc.load_mode = 1'b1;
        tick();
        ifc.load_valid = 1'b1; ifc.load_addr = 11'd7; ifc.load_data = 16'h7777;
        tick();
        ifc.load_addr = 11'd8; ifc.load_data = 16'h8888;
        tick();
        ifc.load_valid = 1'b0; ifc.load_mode = 1'b0;
        tick();
        ifc.fetch_req = 1'b1; ifc.PC = 11'd7;
        tick();
        ifc.fetch_req = 1'b0;
        tick();
        total++; if (ifc.instr_valid !== 1'b0) $display("FAIL t4_early: got %b exp 0", ifc.instr_valid); else passed++;
        tick();
        total++; if (ifc.instr_valid !== 1'b1) $display("FAIL t4_valid: got %b exp 1", ifc.instr_valid); else passed++;
        total++; if (ifc.Instruction !== 16'h7777) $display("FAIL t4_instr: got %h exp 7777", ifc.Instruction); else passed++;
        tick();
        ifc.fetch_req = 1'b1; ifc.PC = 11'd8;
        tick();
        ifc.fetch_req = 1'b0; ifc.load_mode = 1'b1;
        tick();
        total++; if (ifc.load_ready !== 1'b1) $display("FAIL t4_ready: got %b exp 1", ifc.load_ready); else passed++;
        total++; if (ifc.instr_valid !== 1'b0) $display("FAIL t4_novalid: got %b exp 0", ifc.instr_valid); else passed++;
        total++; if (ifc.Instruction !== 16'h7777) $display("FAIL t4_keep: got %h exp 7777", ifc.Instruction); else passed++;
        ifc.load_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ifc.instr_valid !== 1'b0) $display("FAIL t4_late[%0d]: got %b exp 0", i, ifc.instr_valid); else passed++;
        end
    endtask

    task automatic test_async_reset();
        ifb.fetch_req = 1'b1; ifb.PC = 11'd1;
        tick();
        ifb.fetch_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (ifb.busy !== 1'b0) $display("FAIL t6_wait_busy: got %b exp 0", ifb.busy); else passed++;
        total++; if (ifb.Instruction !== 16'h0000) $display("FAIL t6_wait_instr: got %h exp 0000", ifb.Instruction); else passed++;
        total++; if (ifb.load_count !== 11'd0) $display("FAIL t6_wait_count: got %0d exp 0", ifb.load_count); else passed++;
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ifb.instr_valid !== 1'b0) $display("FAIL t6_nopulse[%0d]: got %b exp 0", i, ifb.instr_valid); else passed++;
        end
        ifb.load_mode = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++; if (ifb.load_ready !== 1'b0) $display("FAIL t6_load_ready: got %b exp 0", ifb.load_ready); else passed++;
        total++; if (ifb.busy !== 1'b0) $display("FAIL t6_load_busy: got %b exp 0", ifb.busy); else passed++;
        ifb.load_mode = 1'b0;
        #2 reset = 1'b0;
        tick();
        ifb.fetch_req = 1'b1; ifb.PC = 11'd1;
        tick();
        ifb.fetch_req = 1'b0;
        repeat (3) tick();
        total++; if (ifb.instr_valid !== 1'b1) $display("FAIL t6_valid: got %b exp 1", ifb.instr_valid); else passed++;
        total++; if (ifb.Instruction !== 16'h2222) $display("FAIL t6_kept: got %h exp 2222", ifb.Instruction); else passed++;
        tick();
    endtask

    initial begin
        ifa.fetch_req = 1'b0; ifa.PC = '0; ifa.load_mode = 1'b0; ifa.load_valid = 1'b0; ifa.load_addr = '0; ifa.load_data = '0;
        ifb.fetch_req = 1'b0; ifb.PC = '0; ifb.load_mode = 1'b0; ifb.load_valid = 1'b0; ifb.load_addr = '0; ifb.load_data = '0;
        ifc.fetch_req = 1'b0; ifc.PC = '0; ifc.load_mode = 1'b0; ifc.load_valid = 1'b0; ifc.load_addr = '0; ifc.load_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        test_reset();
        test_fetch_nowait();
        test_back_to_back();
        test_load_then_fetch();
        test_out_of_range();
        test_wait_states();
        test_wait_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1);
    end
endmodule
